ntlm_msg_block: RTL



---
 rtl/ntlm_msg_block.sv | 108 ++++++++++
 1 files changed

// File: rtl/ntlm_msg_block.sv
// NTLM message-block builder: latches one ASCII password, widens it to UTF-16LE,
// appends MD4 padding and bit length, and streams the 16 words of the block.
module ntlm_msg_block #(
  parameter int MAX_CHARS = 16,
  parameter int WORD_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*MAX_CHARS-1:0] guess_in,
  input  logic [4:0]             length_in,
  input  logic                   guess_valid,
  output logic                   guess_ready,
  output logic [WORD_W-1:0]      word_out,
  output logic [3:0]             word_idx,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   block_last,
  output logic                   len_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             idx_reg, idx_next;
  logic [8*MAX_CHARS-1:0] chars_reg;
  logic [4:0]             len_reg;
  logic                   len_err_reg, len_err_next;
  logic                   load;
  logic                   len_legal;

  // Message viewed as 28 UTF-16 code units (bytes 0..55) plus two length words.
  logic [15:0]       half [0:27];
  logic [WORD_W-1:0] word_arr [0:15];

  assign len_legal = (length_in != 5'd0) && (length_in <= 5'(MAX_CHARS));

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    len_err_next = 1'b0;
    load         = 1'b0;
    guess_ready  = 1'b0;
    word_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        guess_ready = !rst;
        if (guess_valid) begin
          load     = 1'b1;
          idx_next = 4'd0;
          if (len_legal) state_next = EMIT;
          else           len_err_next = 1'b1;
        end
      end
      EMIT: begin
        word_valid = 1'b1;
        if (word_ready) begin
          idx_next = idx_reg + 4'd1;
          if (idx_reg == 4'd15) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= 4'd0;
      len_err_reg <= 1'b0;
      chars_reg   <= '0;
      len_reg     <= 5'd0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      len_err_reg <= len_err_next;
      if (load) begin
        chars_reg <= guess_in;
        len_reg   <= length_in;
      end
    end
  end

  // Characters at or beyond the length are masked; the unit at the length holds 0x80.
  generate
    for (genvar gi = 0; gi < 28; gi++) begin : g_half
      if (gi < MAX_CHARS) begin : g_char
        assign half[gi] = (5'(gi) < len_reg)  ? {8'h00, chars_reg[8*gi +: 8]} :
                          (5'(gi) == len_reg) ? 16'h0080 : 16'h0000;
      end else if (gi == MAX_CHARS) begin : g_pad
        assign half[gi] = (5'(gi) == len_reg) ? 16'h0080 : 16'h0000;
      end else begin : g_zero
        assign half[gi] = 16'h0000;
      end
    end
    for (genvar gi = 0; gi < 14; gi++) begin : g_word
      assign word_arr[gi] = {half[2*gi+1], half[2*gi]};
    end
  endgenerate

  assign word_arr[14] = {{(WORD_W-9){1'b0}}, len_reg, 4'b0000};
  assign word_arr[15] = '0;

  assign word_out   = word_valid ? word_arr[idx_reg] : '0;
  assign word_idx   = word_valid ? idx_reg : 4'd0;
  assign block_last = word_valid && (idx_reg == 4'd15);
  assign len_err    = len_err_reg;

endmodule
